// File: rtl/dbg_uart2apb_pkg.sv
// dbg_uart2apb: shared FSM states and
// byte-field positions for the debug bridge.
package dbg_uart2apb_pkg;

  typedef enum logic [2:0] {
    S_CMD,
    S_LEN,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_SEND_RDATA,
    S_STATUS
  } state_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_FIX_BIT   = 6;
  localparam int ST_SLVERR_BIT = 7;
  localparam int ST_TMO_BIT    = 6;
  localparam int ERR_CNT_W     = 6;

endpackage

// File: rtl/dbg_apb_timeout.sv
// dbg_apb_timeout: pready wait counter;
// expires on the wait cycle that makes it all-ones.
module dbg_apb_timeout #(
  parameter int TIMEOUT_W = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LAST =
    {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign o_expired = i_en && (cnt_q == LAST);

endmodule

// File: rtl/dbg_uart2apb_gen.sv
// dbg_uart2apb_gen: UART byte stream to APB
// master bridge with timeout and burst status.
module dbg_uart2apb_gen
  import dbg_uart2apb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_INC  = DATA_W / 8,
  parameter int TIMEOUT_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fifo_empty,
  output logic              o_fifo_read,
  input  logic [7:0]        i_fifo_rdata,
  input  logic              i_fifo_full,
  output logic              o_fifo_write,
  output logic [7:0]        o_fifo_wdata,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic              i_pready,
  input  logic              i_pslverr,
  input  logic [DATA_W-1:0] i_prdata
);

  localparam int AB  = ADDR_W / 8;
  localparam int DB  = DATA_W / 8;
  localparam int MB  = (AB > DB) ? AB : DB;
  localparam int BCW = (MB > 1) ? $clog2(MB) : 1;
  localparam logic [BCW-1:0] A_LAST = BCW'(AB - 1);
  localparam logic [BCW-1:0] D_LAST = BCW'(DB - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t                state_q, state_d;
  logic [BCW-1:0]        bcnt_q;
  logic                  wr_q, fix_q;
  logic [7:0]            len_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q;
  logic                  slverr_q, tmo_q;
  logic [ERR_CNT_W-1:0]  errs_q;
  logic                  pop, push, done;
  logic                  tmo_clr, tmo_en, expired;
  logic                  beat_err, a_last, d_last;
  logic [7:0]            rbyte, st_byte;

  assign pop = (state_q inside {S_CMD, S_LEN, S_ADDR, S_WDATA})
               && !i_fifo_empty;
  assign push = (state_q inside {S_SEND_RDATA, S_STATUS})
                && !i_fifo_full;
  assign tmo_clr  = (state_q == S_SETUP);
  assign tmo_en   = (state_q == S_ACCESS) && !i_pready;
  assign done     = (state_q == S_ACCESS) && (i_pready || expired);
  assign beat_err = i_pready ? i_pslverr : 1'b1;
  assign a_last   = (bcnt_q == A_LAST);
  assign d_last   = (bcnt_q == D_LAST);

  dbg_apb_timeout #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_tmo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (tmo_clr),
    .i_en      (tmo_en),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_CMD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CMD:   if (pop) state_d = S_LEN;
      S_LEN:   if (pop) state_d = S_ADDR;
      S_ADDR:
        if (pop && a_last)
          state_d = wr_q ? S_WDATA : S_SETUP;
      S_WDATA: if (pop && d_last) state_d = S_SETUP;
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS:
        if (done) begin
          if (!wr_q)            state_d = S_SEND_RDATA;
          else if (len_q != 0)  state_d = S_WDATA;
          else                  state_d = S_STATUS;
        end
      S_SEND_RDATA:
        if (push && d_last)
          state_d = (len_q != 0) ? S_SETUP : S_STATUS;
      S_STATUS: if (push) state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bcnt_q   <= '0;
      wr_q     <= 1'b0;
      fix_q    <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tmo_q    <= 1'b0;
      errs_q   <= '0;
    end else begin
      unique case (state_q)
        S_CMD:
          if (pop) begin
            wr_q  <= i_fifo_rdata[CMD_WRITE_BIT];
            fix_q <= i_fifo_rdata[CMD_FIX_BIT];
          end
        S_LEN: if (pop) len_q <= i_fifo_rdata;
        S_ADDR:
          if (pop) begin
            addr_q <= (addr_q << 8) | ADDR_W'(i_fifo_rdata);
            bcnt_q <= a_last ? '0 : bcnt_q + BCW'(1);
          end
        S_WDATA:
          if (pop) begin
            wdata_q <= (wdata_q << 8) | DATA_W'(i_fifo_rdata);
            bcnt_q  <= d_last ? '0 : bcnt_q + BCW'(1);
          end
        S_ACCESS:
          if (done) begin
            rdata_q <= i_pready ? i_prdata : '0;
            if (i_pready && i_pslverr) slverr_q <= 1'b1;
            if (!i_pready)             tmo_q    <= 1'b1;
            if (beat_err && errs_q != ERR_MAX)
              errs_q <= errs_q + ERR_CNT_W'(1);
            if (!fix_q) addr_q <= addr_q + ADDR_W'(ADDR_INC);
            if (wr_q && len_q != 0) len_q <= len_q - 8'd1;
          end
        S_SEND_RDATA:
          if (push) begin
            bcnt_q <= d_last ? '0 : bcnt_q + BCW'(1);
            if (d_last && len_q != 0) len_q <= len_q - 8'd1;
          end
        S_STATUS:
          if (push) begin
            slverr_q <= 1'b0;
            tmo_q    <= 1'b0;
            errs_q   <= '0;
          end
        default: ;
      endcase
    end
  end

  // Read bytes leave MSB first; status packs flags over the error count.
  always_comb begin
    rbyte   = 8'(rdata_q >> ((DB - 1 - int'(bcnt_q)) * 8));
    st_byte = '0;
    st_byte[ERR_CNT_W-1:0] = errs_q;
    st_byte[ST_SLVERR_BIT] = slverr_q;
    st_byte[ST_TMO_BIT]    = tmo_q;
    o_fifo_wdata = 8'h00;
    if (state_q == S_SEND_RDATA) o_fifo_wdata = rbyte;
    if (state_q == S_STATUS)     o_fifo_wdata = st_byte;
  end

  assign o_fifo_read  = pop;
  assign o_fifo_write = push;
  assign o_psel       = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign o_penable    = (state_q == S_ACCESS);
  assign o_pwrite     = wr_q;
  assign o_paddr      = addr_q;
  assign o_pwdata     = wdata_q;

endmodule

// File: tb/tb_dbg_uart2apb_gen.sv
// tb_dbg_uart2apb_gen: scoreboard bench with RX/TX
// FIFO models and a scripted APB slave.
module tb_dbg_uart2apb_gen;

  localparam int TMO_LIM = 4095;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_t;

  typedef struct {
    int          wt;
    bit          err;
    logic [31:0] data;
  } slv_t;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_fifo_empty;
  logic        o_fifo_read;
  logic [7:0]  i_fifo_rdata;
  logic        i_fifo_full;
  logic        o_fifo_write;
  logic [7:0]  o_fifo_wdata;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_paddr;
  logic [31:0] o_pwdata;
  logic        i_pready;
  logic        i_pslverr;
  logic [31:0] i_prdata;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  apb_t       apbq[$];
  slv_t       slvq[$];

  int checks = 0;
  int failures = 0;
  int acc_cyc = 0;
  int last_acc_len = 0;
  int n_apb = 0;
  bit pop_pend, prev_pop, prev_push;
  bit prev_setup, prev_access;
  bit rx_gap, tx_bp;
  logic [31:0] setup_addr, setup_data;
  logic        setup_wr;

  always #5 clk = ~clk;

  dbg_uart2apb_gen dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_read  (o_fifo_read),
    .i_fifo_rdata (i_fifo_rdata),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_write (o_fifo_write),
    .o_fifo_wdata (o_fifo_wdata),
    .o_psel       (o_psel),
    .o_penable    (o_penable),
    .o_pwrite     (o_pwrite),
    .o_paddr      (o_paddr),
    .o_pwdata     (o_pwdata),
    .i_pready     (i_pready),
    .i_pslverr    (i_pslverr),
    .i_prdata     (i_prdata)
  );

  // FIFO and slave models plus scoreboard monitor
  initial begin
    forever begin
      slv_t s;
      apb_t e;
      logic [7:0] eb;
      @(negedge clk);
      if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
      i_fifo_empty = (rxq.size() == 0) ||
                     (rx_gap && $urandom_range(0, 1) == 1);
      i_fifo_rdata = i_fifo_empty ? 8'h00 : rxq[0];
      i_fifo_full = tx_bp && ($urandom_range(0, 1) == 1);
      if (!(o_psel && o_penable)) acc_cyc = 0;
      s.wt = 0;
      s.err = 1'b0;
      s.data = 32'h0;
      if (slvq.size() > 0) s = slvq[0];
      i_pready = o_psel && o_penable && s.wt >= 0 &&
                 acc_cyc >= s.wt;
      i_pslverr = i_pready ? s.err : 1'b1;
      i_prdata = i_pready ? s.data : 32'hBAD0_BAD0;
      #1;
      pop_pend = o_fifo_read;
      if (i_fifo_empty) begin
        checks++;
        if (o_fifo_read) begin
          failures++;
          $display("FAIL rx_pop_empty read=%0b want 0",
                   o_fifo_read);
        end
      end
      if (i_fifo_full) begin
        checks++;
        if (o_fifo_write) begin
          failures++;
          $display("FAIL tx_push_full write=%0b want 0",
                   o_fifo_write);
        end
      end
      if (o_fifo_write) begin
        checks++;
        if (txq.size() == 0) begin
          failures++;
          $display("FAIL tx_extra got=%02h want none",
                   o_fifo_wdata);
        end else begin
          eb = txq.pop_front();
          if (o_fifo_wdata !== eb) begin
            failures++;
            $display("FAIL tx_byte got=%02h want=%02h",
                     o_fifo_wdata, eb);
          end
        end
      end
      if (o_psel && !o_penable) begin
        checks++;
        if (prev_setup || !(prev_pop || prev_push)) begin
          failures++;
          $display("FAIL setup_seq prev_setup=%0b pop=%0b push=%0b want 0,1",
                   prev_setup, prev_pop, prev_push);
        end
        setup_addr = o_paddr;
        setup_data = o_pwdata;
        setup_wr = o_pwrite;
      end
      if (o_psel && o_penable) begin
        acc_cyc++;
        checks++;
        if (!(prev_setup || prev_access)) begin
          failures++;
          $display("FAIL access_seq got access without setup");
        end
        if (i_pready || acc_cyc >= TMO_LIM) begin
          n_apb++;
          last_acc_len = acc_cyc;
          acc_cyc = 0;
          if (slvq.size() > 0) void'(slvq.pop_front());
          checks++;
          if (apbq.size() == 0) begin
            failures++;
            $display("FAIL apb_extra addr=%08h want none", o_paddr);
          end else begin
            e = apbq.pop_front();
            if (o_pwrite !== e.wr || o_paddr !== e.addr ||
                (e.wr && o_pwdata !== e.data) ||
                o_paddr !== setup_addr || o_pwrite !== setup_wr ||
                o_pwdata !== setup_data) begin
              failures++;
              $display("FAIL apb_xfer got w=%0b a=%08h d=%08h want w=%0b a=%08h d=%08h",
                       o_pwrite, o_paddr, o_pwdata,
                       e.wr, e.addr, e.data);
            end
          end
        end
      end
      prev_setup = o_psel && !o_penable;
      prev_access = o_psel && o_penable;
      prev_pop = o_fifo_read;
      prev_push = o_fifo_write;
    end
  end

  task automatic put_hdr(input logic [7:0] cmd, input int len,
                         input logic [31:0] a);
    rxq.push_back(cmd);
    rxq.push_back(8'(len - 1));
    for (int i = 3; i >= 0; i--) rxq.push_back(a[8*i +: 8]);
  endtask

  task automatic wr_beat(input logic [31:0] a, input int w_cyc,
                         input logic [31:0] d);
    for (int i = 3; i >= 0; i--) rxq.push_back(d[8*i +: 8]);
    slvq.push_back('{wt: w_cyc, err: 1'b0, data: 32'h0});
    apbq.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic rd_beat(input logic [31:0] a, input int w_cyc,
                         input bit e, input logic [31:0] d);
    slvq.push_back('{wt: w_cyc, err: e, data: d});
    apbq.push_back('{wr: 1'b0, addr: a, data: 32'h0});
    for (int i = 3; i >= 0; i--)
      txq.push_back(w_cyc < 0 ? 8'h00 : d[8*i +: 8]);
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #2;
      if (rxq.size() == 0 && txq.size() == 0 &&
          apbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({o_psel, o_penable, o_pwrite, o_fifo_read,
         o_fifo_write} !== 5'b0 || o_paddr !== 32'h0 ||
        o_pwdata !== 32'h0 || o_fifo_wdata !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs psel=%0b pen=%0b addr=%08h want all 0",
               o_psel, o_penable, o_paddr);
    end
    i_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if ({o_psel, o_penable, o_fifo_read, o_fifo_write} !== 4'b0) begin
      failures++;
      $display("FAIL idle_outputs psel=%0b pen=%0b rd=%0b wr=%0b want 0",
               o_psel, o_penable, o_fifo_read, o_fifo_write);
    end
  endtask

  task automatic test_single_write;
    bit ok;
    int n0 = n_apb;
    put_hdr(8'h80, 1, 32'h0000_1000);
    wr_beat(32'h0000_1000, 0, 32'hDEAD_BEEF);
    txq.push_back(8'h00);
    drain(200, ok);
    checks++;
    if (!ok || n_apb - n0 != 1) begin
      failures++;
      $display("FAIL single_write done=%0b xfers=%0d want 1,1",
               ok, n_apb - n0);
    end
  endtask

  task automatic test_read_burst;
    bit ok;
    int n0 = n_apb;
    put_hdr(8'h00, 2, 32'h0000_0020);
    rd_beat(32'h0000_0020, 1, 1'b0, 32'h1122_3344);
    rd_beat(32'h0000_0024, 0, 1'b0, 32'h5566_7788);
    txq.push_back(8'h00);
    drain(300, ok);
    checks++;
    if (!ok || n_apb - n0 != 2) begin
      failures++;
      $display("FAIL read_burst done=%0b xfers=%0d want 1,2",
               ok, n_apb - n0);
    end
  endtask

  task automatic test_fixed_write;
    bit ok;
    int n0 = n_apb;
    rx_gap = 1'b1;
    put_hdr(8'hC0, 3, 32'h0000_0040);
    wr_beat(32'h0000_0040, 0, 32'hA0A1_A2A3);
    wr_beat(32'h0000_0040, 2, 32'hB0B1_B2B3);
    wr_beat(32'h0000_0040, 0, 32'hC0C1_C2C3);
    txq.push_back(8'h00);
    drain(500, ok);
    rx_gap = 1'b0;
    checks++;
    if (!ok || n_apb - n0 != 3) begin
      failures++;
      $display("FAIL fixed_write done=%0b xfers=%0d want 1,3",
               ok, n_apb - n0);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    put_hdr(8'h00, 1, 32'h0000_0300);
    rd_beat(32'h0000_0300, -1, 1'b0, 32'h0);
    txq.push_back(8'h41);
    drain(6000, ok);
    checks++;
    if (!ok || last_acc_len != TMO_LIM) begin
      failures++;
      $display("FAIL timeout done=%0b access_cycles=%0d want 1,%0d",
               ok, last_acc_len, TMO_LIM);
    end
  endtask

  task automatic test_slverr_backpressure;
    bit ok;
    tx_bp = 1'b1;
    put_hdr(8'h00, 2, 32'h0000_0500);
    rd_beat(32'h0000_0500, 2, 1'b1, 32'hCAFE_F00D);
    rd_beat(32'h0000_0504, 0, 1'b0, 32'h1234_5678);
    txq.push_back(8'h81);
    drain(400, ok);
    tx_bp = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL slverr_bp done=%0b want 1", ok);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n0 = n_apb;
    rx_gap = 1'b1;
    tx_bp = 1'b1;
    put_hdr(8'hBF, 2, 32'hFFFF_FFFC);
    wr_beat(32'hFFFF_FFFC, 1, 32'h0000_0001);
    wr_beat(32'h0000_0000, 0, 32'h0000_0002);
    txq.push_back(8'h00);
    put_hdr(8'h7F, 2, 32'h0000_0600);
    rd_beat(32'h0000_0600, 0, 1'b0, 32'hA5A5_A5A5);
    rd_beat(32'h0000_0600, 3, 1'b0, 32'h5A5A_5A5A);
    txq.push_back(8'h00);
    drain(800, ok);
    rx_gap = 1'b0;
    tx_bp = 1'b0;
    checks++;
    if (!ok || n_apb - n0 != 4) begin
      failures++;
      $display("FAIL back_to_back done=%0b xfers=%0d want 1,4",
               ok, n_apb - n0);
    end
  endtask

  task automatic test_err_saturate;
    bit ok;
    put_hdr(8'h00, 70, 32'h0000_1000);
    for (int i = 0; i < 70; i++)
      rd_beat(32'h0000_1000 + 32'(4 * i), 0, 1'b1,
              32'(i) * 32'h0101_0101);
    txq.push_back(8'hBF);
    drain(3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL err_saturate done=%0b want 1", ok);
    end
  endtask

  task automatic test_reset_mid_access;
    bit ok;
    bit seen = 1'b0;
    put_hdr(8'h00, 1, 32'h0000_0800);
    rd_beat(32'h0000_0800, 1000, 1'b0, 32'h0);
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      #2;
      seen = o_psel && o_penable;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reach_access seen=%0b want 1", seen);
    end
    repeat (2) @(negedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_psel !== 1'b0 || o_penable !== 1'b0) begin
      failures++;
      $display("FAIL async_drop psel=%0b pen=%0b want 0,0",
               o_psel, o_penable);
    end
    rxq.delete();
    txq.delete();
    apbq.delete();
    slvq.delete();
    acc_cyc = 0;
    @(negedge clk);
    #3;
    i_rst_n = 1'b1;
    put_hdr(8'h80, 1, 32'h0000_0900);
    wr_beat(32'h0000_0900, 0, 32'h0BAD_F00D);
    txq.push_back(8'h00);
    drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL after_reset done=%0b want 1", ok);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_rdata = 8'h00;
    i_fifo_full = 1'b0;
    i_pready = 1'b0;
    i_pslverr = 1'b0;
    i_prdata = 32'h0;
    rx_gap = 1'b0;
    tx_bp = 1'b0;
    test_reset;
    test_single_write;
    test_read_burst;
    test_fixed_write;
    test_timeout;
    test_slverr_backpressure;
    test_back_to_back;
    test_err_saturate;
    test_reset_mid_access;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_uart2apb_gen.md
Name: dbg_uart2apb_gen

Overview:
- Parametrised UART-byte-stream to APB master bridge for the debug port.
- Sits between the debug UART RX/TX FIFOs and the chip APB fabric.
- Decodes command, burst length, address and write data from the RX byte stream, and issues full APB setup/access transfers with psel.
- Adds a pready timeout, pslverr capture, and a per-burst status byte on TX.

Parameters:
- ADDR_W, 32, APB address width; multiple of 8, range 8..64.
- DATA_W, 32, APB data width; multiple of 8, range 8..64.
- ADDR_INC, DATA_W/8, address increment per beat when fix_addr=0.
- TIMEOUT_W, 12, pready timeout counter width; timeout after 2^TIMEOUT_W-1 wait cycles.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_fifo_empty  in  1  RX FIFO empty
- o_fifo_read  out  1  RX pop; data valid same cycle (show-ahead FIFO)
- i_fifo_rdata  in  8  RX byte
- i_fifo_full  in  1  TX FIFO full
- o_fifo_write  out  1  TX push
- o_fifo_wdata  out  8  TX byte
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction
- o_paddr  out  ADDR_W  APB address
- o_pwdata  out  DATA_W  APB write data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error
- i_prdata  in  DATA_W  APB read data

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk. All outputs 0, FSM in CMD, all counters and flags 0.
- Reset mid-operation: bus is dropped immediately (psel/penable=0) and the FSM returns to CMD.
- Byte 0 (command): bit7=write, bit6=fix_addr, bits5:0 ignored.
- Byte 1: burst length minus 1 (0..255, i.e. 1..256 beats).
- Address: ADDR_W/8 bytes, MSB first.
- Write beat: DATA_W/8 data bytes, MSB first.
- RX pop: o_fifo_read=1 only when !i_fifo_empty; exactly one byte consumed per pop cycle.
- States:
  - CMD: pop 1 byte -> LEN.
  - LEN: pop 1 byte -> ADDR.
  - ADDR: after the last address byte -> WDATA if write, else SETUP.
  - WDATA: after the last data byte -> SETUP.
  - SETUP: psel=1, penable=0, exactly 1 cycle -> ACCESS.
  - ACCESS: psel=1, penable=1; completes on the first cycle with i_pready=1, or on timeout.
  - On completion, reads -> SEND_RDATA; writes -> WDATA if beats remain, else STATUS.
  - SEND_RDATA: push DATA_W/8 bytes MSB first -> SETUP if beats remain, else STATUS.
  - STATUS: push 1 status byte -> CMD.
- Write latency: the SETUP cycle immediately follows the pop cycle of the last data byte.
- Read latency: the SETUP cycle immediately follows the last address byte pop, or the last byte push of the previous beat.
- TX push: o_fifo_write=1 only when !i_fifo_full; the byte is held stable while full.
- Read capture: i_prdata captured on the completing cycle; 0 captured on timeout.
- o_pwrite, o_paddr and o_pwdata are stable from SETUP through ACCESS completion.
- Address advance: after each completed beat, o_paddr += ADDR_INC unless fix_addr; wraps modulo 2^ADDR_W.
- Timeout:
  - Counter clears on SETUP and increments each ACCESS cycle with i_pready=0.
  - When it reaches all-ones with i_pready still 0, the access is aborted: psel/penable=0 next cycle, timeout flag set, burst continues.
- i_pslverr is sampled only on the completing cycle with i_pready=1.
- Status byte:
  - bit7 = any pslverr in the burst.
  - bit6 = any timeout in the burst.
  - bits5:0 = count of errored beats, saturating at 63.
  - Flags clear on entry to CMD.
- The byte counter width is clog2 of max(ADDR_W,DATA_W)/8, minimum 1.
- The FSM does not check i_fifo_empty outside the pop states.

Decomposition:
- Package dbg_uart2apb_pkg: FSM state enum, command bit positions (CMD_WRITE_BIT=7, CMD_FIX_BIT=6), status bit positions (ST_SLVERR_BIT=7, ST_TMO_BIT=6).
- Sub-module dbg_apb_timeout: TIMEOUT_W counter with clear/enable inputs and an expired output.

Test Plan:
- Single write: bytes 0x80,0x00,0x00,0x00,0x10,0x00,0xDE,0xAD,0xBE,0xEF, pready=1 -> one APB write, paddr=0x1000, pwdata=0xDEADBEEF, SETUP 1 cycle, then TX status 0x00.
- Incrementing read burst: 0x00,0x01,addr 0x00000020, slave returns 0x11223344 then 0x55667788 -> paddr 0x20 then 0x24; TX 11 22 33 44 55 66 77 88 00.
- Fixed-address write burst: 0xC0,0x02, addr 0x40, 3 data words -> three writes, all paddr=0x40.
- Timeout: read, pready held 0 -> access aborted after 4095 ACCESS cycles; TX 00 00 00 00 41.
- Slave error plus backpressure: read with pslverr=1 on the completing cycle, i_fifo_full toggled -> no byte lost or duplicated; status 0x81.
- Reset asserted during ACCESS -> psel/penable=0 asynchronously; the next command decodes correctly.
